// File: rtl/cpu_in_port.sv
// cpu_in_port: four per-port input FIFOs filled by a valid/ready producer and popped by the cpu
module cpu_in_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ext_valid,
    input  logic [1:0]  i_ext_port,
    input  logic [15:0] i_ext_data,
    output logic        o_ext_ready,
    input  logic        i_rd_en,
    input  logic [1:0]  i_rd_port,
    output logic [15:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_rd_err,
    output logic [3:0]  o_not_empty,
    output logic [3:0]  o_full
);

    logic [15:0]   r_mem [4][DEPTH];
    logic [AW-1:0] r_wr_ptr [4];
    logic [AW-1:0] r_rd_ptr [4];
    logic [AW:0]   r_cnt [4];
    logic [AW:0]   w_cnt_nxt [4];
    logic [15:0]   r_rd_data;
    logic          r_rd_valid;
    logic          r_rd_err;
    logic [3:0]    r_not_empty;
    logic [3:0]    r_full;
    logic          w_push;
    logic          w_pop;
    logic [3:0]    w_push_sel;
    logic [3:0]    w_pop_sel;

    // Ready comes only from the registered full flag, so a same-cycle pop never frees a slot early.
    assign o_ext_ready = ~r_full[i_ext_port];
    assign w_push      = i_ext_valid & o_ext_ready;
    assign w_pop       = i_rd_en & r_not_empty[i_rd_port];
    assign w_push_sel  = w_push ? (4'b0001 << i_ext_port) : 4'b0000;
    assign w_pop_sel   = w_pop ? (4'b0001 << i_rd_port) : 4'b0000;

    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_err    = r_rd_err;
    assign o_not_empty = r_not_empty;
    assign o_full      = r_full;

    // Post-edge occupancy per port; a push and pop on the same port cancel out.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            w_cnt_nxt[p] = r_cnt[p] + (AW+1)'(w_push_sel[p]) - (AW+1)'(w_pop_sel[p]);
        end
    end

    // Storage write; reset discards any push in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset && w_push) begin
            r_mem[i_ext_port][r_wr_ptr[i_ext_port]] <= i_ext_data;
        end
    end

    // Pointers, counts, flags and the registered pop result.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int p = 0; p < 4; p++) begin
                r_wr_ptr[p] <= '0;
                r_rd_ptr[p] <= '0;
                r_cnt[p]    <= '0;
            end
            r_not_empty <= 4'b0000;
            r_full      <= 4'b0000;
            r_rd_data   <= 16'h0000;
            r_rd_valid  <= 1'b0;
            r_rd_err    <= 1'b0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (w_push_sel[p]) begin
                    r_wr_ptr[p] <= r_wr_ptr[p] + AW'(1);
                end
                if (w_pop_sel[p]) begin
                    r_rd_ptr[p] <= r_rd_ptr[p] + AW'(1);
                end
                r_cnt[p]       <= w_cnt_nxt[p];
                r_not_empty[p] <= (w_cnt_nxt[p] != '0);
                r_full[p]      <= (w_cnt_nxt[p] == (AW+1)'(DEPTH));
            end
            r_rd_valid <= w_pop;
            r_rd_err   <= i_rd_en & ~r_not_empty[i_rd_port];
            if (w_pop) begin
                r_rd_data <= r_mem[i_rd_port][r_rd_ptr[i_rd_port]];
            end
        end
    end

endmodule

// File: doc/cpu_in_port.md
Name: cpu_in_port

Overview:
- Input-side peripheral for the cpu. The cpu drives four 16-bit output ports; this block supplies data in the other direction.
- External producers push 16-bit words, tagged with a port number 0..3, over a valid/ready handshake.
- Each word goes into one of four per-port FIFOs.
- The cpu pops words by port number with a read strobe and gets registered data one cycle later.

Parameters:
- DEPTH, 4, entries per port FIFO; power of two, minimum 2.
- AW, 2, log2(DEPTH); pointer width. The occupancy counter is AW+1 bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- ext_valid  input  1  producer offers a word this cycle.
- ext_port  input  2  target port for ext_data.
- ext_data  input  16  word offered.
- ext_ready  output  1  block accepts the offered word this cycle.
- rd_en  input  1  cpu requests a pop.
- rd_port  input  2  port to pop.
- rd_data  output  16  popped word, registered.
- rd_valid  output  1  rd_data holds a fresh popped word; 1-cycle pulse.
- rd_err  output  1  pop of an empty port was attempted; 1-cycle pulse.
- not_empty  output  4  per-port occupancy > 0, registered.
- full  output  4  per-port occupancy == DEPTH, registered.

Behaviour:
- Reset (reset==0 at a rising edge):
  - All pointers and counters cleared.
  - rd_data=16'h0000, rd_valid=0, rd_err=0, not_empty=4'b0000, full=4'b0000.
  - Any push or pop in flight that cycle is discarded.
  - Reset overrides all other activity.
- Push handshake:
  - ext_ready = ~full[ext_port]. This is combinational from the registered full flag.
  - A push occurs at a rising edge when ext_valid && ext_ready.
  - ext_data is written at wr_ptr[ext_port]; that wr_ptr increments mod DEPTH and that count increments.
  - The producer holds ext_valid, ext_port and ext_data until it is accepted.
  - ext_ready does not depend on a same-cycle pop, so a full port refuses a push even when it is being popped that cycle.
- Pop:
  - At a rising edge with rd_en==1 and not_empty[rd_port]==1: rd_data <= entry at rd_ptr[rd_port]; rd_valid <= 1; that rd_ptr increments mod DEPTH; that count decrements.
  - Pop latency is 1 cycle: the strobe at edge N gives data valid from edge N to edge N+1.
  - rd_en with not_empty[rd_port]==0: rd_valid <= 0, rd_err <= 1, rd_data holds its previous value.
  - rd_en==0: rd_valid <= 0, rd_err <= 0, rd_data holds.
- Simultaneous events:
  - Push and pop on the same non-empty port: both take effect, count unchanged, FIFO order preserved.
  - Push and pop on an empty port: the pop fails (rd_err), the push lands, and the new word is not bypassed.
  - Push and pop on different ports: independent.
- Flag timing:
  - not_empty and full are recomputed from the post-edge counts and registered.
  - A word pushed at edge N is poppable by a strobe at edge N+1 or later.
- Wrap-around:
  - Pointers wrap DEPTH-1 -> 0.
  - Data order is strict FIFO per port across the wrap.
- Widths: data is passed unmodified; no sign handling. The count is AW+1 bits so that DEPTH is representable.

Test Plan:
- Reset then idle (60 ns clock, reset low for the first edge) -> rd_data=0000, rd_valid=0, not_empty=0000, full=0000, ext_ready=1 for every ext_port.
- Push 16'h1234 to port 2, then rd_en with rd_port=2 on the next edge -> not_empty=0100 after the push; after the pop edge rd_data=1234, rd_valid=1 for one cycle, not_empty=0000.
- Fill port 1 with 16'h0001..16'h0004 -> full=0010 and ext_ready=0 for ext_port=1; a fifth push of 16'h0005 is not accepted; 4 pops return 0001, 0002, 0003, 0004 in order.
- Wrap-around on port 0:
  - Push A1, A2, A3; pop twice; push A4, A5, A6.
  - Pop 4 times -> A3, A4, A5, A6; not_empty[0]=0.
- Simultaneous events:
  - Port 3 holds one word BEEF.
  - Same edge: push CAFE to port 3 and pop port 3 -> rd_data=BEEF; not_empty[3] stays 1; the next pop returns CAFE.
  - Pop of empty port 1 -> rd_err=1 for one cycle, rd_valid=0, rd_data unchanged.
- Reset mid-operation:
  - Ports 0 and 2 partially filled, reset low during a push+pop edge -> all flags 0, rd_valid=0, rd_data=0000.
  - After release, a pop of port 0 gives rd_err=1.
